// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Buffered 8N1 UART transmitter. CPU byte stores are queued in a small
// circular FIFO. A baud-rate state machine drains the FIFO onto the serial line.
//
// Ports
//   i_clk          system clock, all state on the rising edge
//   i_rst          synchronous active-high reset
//   i_wr_en        push request, one byte per asserted cycle
//   i_wr_data      byte to push, sampled only when the push is accepted
//   i_clr_overflow clears the sticky overflow flag (a same-cycle set wins)
//   o_tx           serial line, idle high, registered
//   o_busy         high while a frame is on the line
//   o_full         queued count == FIFO_DEPTH
//   o_empty        queued count == 0
//   o_count        bytes queued, excluding the byte being shifted
//   o_overflow     sticky: a push was dropped because the FIFO was full
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (high), then chain the next byte or go idle
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int UART_BAUD  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_wr_en,
  input  logic [7:0]                       i_wr_data,
  input  logic                             i_clr_overflow,
  output logic                             o_tx,
  output logic                             o_busy,
  output logic                             o_full,
  output logic                             o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_count,
  output logic                             o_overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_n;
  logic          full_q;
  logic          empty_q;
  logic          ovf_q;
  logic          push_ok;
  logic          pop;

  // Transmitter
  state_t        state_q, state_n;
  logic [BW-1:0] baud_q, baud_n;
  logic [2:0]    bit_q, bit_n;
  logic [7:0]    shift_q, shift_n;
  logic          tx_q, tx_n;
  logic          baud_last;

  // Fullness is judged on the registered count, so a pop in the same
  // cycle never makes room for a push into a full FIFO.
  assign push_ok   = i_wr_en && (count_q != DEPTH_CNT);
  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    count_n = count_q;
    case ({push_ok, pop})
      2'b10:   count_n = count_q + CW'(1);
      2'b01:   count_n = count_q - CW'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push_ok) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_n;
      full_q  <= (count_n == DEPTH_CNT);
      empty_q <= (count_n == '0);
      if (i_wr_en && !push_ok) begin
        ovf_q <= 1'b1;
      end else if (i_clr_overflow) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr_q];
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift_q[0];
          state_n = S_DATA;
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_q == 3'd7) begin
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            // Shift so the next bit to send is always at shift[0].
            bit_n   = bit_q + 3'd1;
            shift_n = {1'b0, shift_q[7:1]};
            tx_n    = shift_q[1];
          end
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (count_q != '0) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            shift_n = mem[rd_ptr_q];
            tx_n    = 1'b0;
            state_n = S_START;
          end else begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_q + BW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        baud_n  = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  assign o_tx       = tx_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// "edge N" counts rising edges from the one that samples the first push.
// Outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       i_clr_overflow;
  logic       o_tx;
  logic       o_busy;
  logic       o_full;
  logic       o_empty;
  logic [2:0] o_count;
  logic       o_overflow;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (16),
    .UART_BAUD (4),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_en       (i_wr_en),
    .i_wr_data     (i_wr_data),
    .i_clr_overflow(i_clr_overflow),
    .o_tx          (o_tx),
    .o_busy        (o_busy),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_count       (o_count),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Independent line decoder: finds a start bit and samples mid-bit.
  logic [7:0] mon_q[$];
  logic [7:0] mon_byte;
  int         mon_cnt = 0;
  int         mon_err = 0;
  bit         mon_active = 1'b0;

  always @(negedge i_clk) begin
    if (i_rst === 1'b1) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else if (!mon_active) begin
      if (o_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2 && o_tx !== 1'b0) mon_err++;
      if (mon_cnt >= CPB + CPB / 2 && mon_cnt <= 8 * CPB + CPB / 2 &&
          (mon_cnt - CPB / 2) % CPB == 0)
        mon_byte[(mon_cnt - CPB - CPB / 2) / CPB] = o_tx;
      if (mon_cnt == 9 * CPB + CPB / 2) begin
        if (o_tx !== 1'b1) mon_err++;
        mon_q.push_back(mon_byte);
        mon_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [9:0] frame;
  logic [7:0] exp_bytes [5];
  int         errs;
  int         lows;

  initial begin
    i_rst = 1'b1;
    i_wr_en = 1'b0;
    i_wr_data = 8'h00;
    i_clr_overflow = 1'b0;
    ticks(2);
    i_rst = 1'b0;
    tick();

    // 1. Reset from a busy, overflowed state.
    i_wr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      i_wr_data = 8'($urandom_range(0, 255));
      tick();
    end
    i_wr_en = 1'b0;
    ticks($urandom_range(3, 30));
    i_rst = 1'b1;
    ticks(2);
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_busy, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_count", o_count, 0);
    check("rst_ovf", o_overflow, 0);
    i_rst = 1'b0;
    ticks(3);
    check("rst_idle_tx", o_tx, 1);

    // 2. Single byte 0x55.
    mon_q.delete();
    i_wr_en = 1'b1;
    i_wr_data = 8'h55;
    tick();
    i_wr_en = 1'b0;
    check("t2_e0_count", o_count, 1);
    check("t2_e0_empty", o_empty, 0);
    check("t2_e0_tx", o_tx, 1);
    frame = {1'b1, 8'h55, 1'b0};
    errs = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        check("t2_e1_tx", o_tx, 0);
        check("t2_e1_busy", o_busy, 1);
        check("t2_e1_count", o_count, 0);
        check("t2_e1_empty", o_empty, 1);
      end
      if (o_tx !== frame[(k - 1) / CPB]) errs++;
      if (o_busy !== 1'b1) errs++;
    end
    check("t2_waveform", errs, 0);
    tick();
    check("t2_e41_busy", o_busy, 0);
    check("t2_e41_tx", o_tx, 1);
    check("t2_nbytes", mon_q.size(), 1);
    check("t2_byte", mon_q[0], 8'h55);

    // 3. Back-to-back 0xA5, 0x3C.
    ticks(2);
    mon_q.delete();
    i_wr_en = 1'b1;
    i_wr_data = 8'hA5;
    tick();
    i_wr_data = 8'h3C;
    tick();
    i_wr_en = 1'b0;
    check("t3_e1_tx", o_tx, 0);
    check("t3_e1_count", o_count, 1);
    ticks(39);
    check("t3_e40_tx", o_tx, 1);
    check("t3_e40_busy", o_busy, 1);
    tick();
    check("t3_e41_tx", o_tx, 0);
    check("t3_e41_busy", o_busy, 1);
    check("t3_e41_count", o_count, 0);
    ticks(40);
    check("t3_e81_busy", o_busy, 0);
    check("t3_nbytes", mon_q.size(), 2);
    check("t3_byte0", mon_q[0], 8'hA5);
    check("t3_byte1", mon_q[1], 8'h3C);

    // 4 + 6. Overflow, clear, then rejected push on the STOP completion edge.
    ticks(2);
    mon_q.delete();
    i_wr_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      i_wr_data = 8'(i);
      tick();
      if (i == 2) check("t4_e1_tx", o_tx, 0);
      if (i == 5) begin
        check("t4_e4_count", o_count, 4);
        check("t4_e4_full", o_full, 1);
        check("t4_e4_ovf", o_overflow, 0);
      end
    end
    i_wr_en = 1'b0;
    check("t4_e5_ovf", o_overflow, 1);
    check("t4_e5_count", o_count, 4);
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;
    check("t4_e6_ovf_clr", o_overflow, 0);
    ticks(34);
    check("t6_e40_count", o_count, 4);
    check("t6_e40_tx", o_tx, 1);
    // Rejected push with a simultaneous clear: set must win.
    i_wr_en = 1'b1;
    i_wr_data = 8'h77;
    i_clr_overflow = 1'b1;
    tick();
    i_wr_en = 1'b0;
    i_clr_overflow = 1'b0;
    check("t6_e41_ovf", o_overflow, 1);
    check("t6_e41_count", o_count, 3);
    check("t6_e41_full", o_full, 0);
    check("t6_e41_tx", o_tx, 0);
    ticks(165);
    check("t4_idle", o_busy, 0);
    check("t4_nbytes", mon_q.size(), 5);
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < mon_q.size() && mon_q[i] !== exp_bytes[i]) errs++;
    end
    check("t4_bytes", errs, 0);
    i_clr_overflow = 1'b1;
    tick();
    i_clr_overflow = 1'b0;

    // 5. Reset during DATA bit 3 of 0xFF, with 0x00 queued.
    ticks(2);
    mon_q.delete();
    i_wr_en = 1'b1;
    i_wr_data = 8'hFF;
    tick();
    i_wr_data = 8'h00;
    tick();
    i_wr_en = 1'b0;
    ticks(16);
    check("t5_e17_busy", o_busy, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("t5_rst_tx", o_tx, 1);
    check("t5_rst_empty", o_empty, 1);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_count", o_count, 0);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (o_tx !== 1'b1) lows++;
    end
    check("t5_no_low_bits", lows, 0);
    check("t5_nbytes", mon_q.size(), 0);

    check("line_framing", mon_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: the peripheral that consumes CPU byte stores to the UART TX address, decoded by the memory controller.
- Stores enter a small FIFO. A baud-rate state machine serialises them onto o_tx as 8N1 frames.
- The CPU polls o_full/o_count through the memory controller's status register and never stalls.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
UART_BAUD, 115200, line rate in bits/s; CLKS_PER_BIT = CLK_FREQ / UART_BAUD (integer floor), must be >= 2
FIFO_DEPTH, 16, number of byte entries; power of two, >= 2

Ports:
i_clk  input  1  system clock, all state on rising edge
i_rst  input  1  synchronous active-high reset
i_wr_en  input  1  push request, one byte per asserted cycle
i_wr_data  input  8  byte to push
i_clr_overflow  input  1  clears sticky o_overflow
o_tx  output  1  serial line, idle high
o_busy  output  1  high while a frame is on the line (START/DATA/STOP)
o_full  output  1  count == FIFO_DEPTH
o_empty  output  1  count == 0
o_count  output  $clog2(FIFO_DEPTH+1)  bytes currently queued, excluding the one being shifted
o_overflow  output  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, any state):
  - o_tx=1, o_busy=0, o_full=0, o_empty=1, o_count=0, o_overflow=0.
  - FIFO pointers zeroed; FSM to IDLE; bit and baud counters zeroed.
  - Reset mid-frame aborts the frame: o_tx is high from the cycle after the reset edge, and all queued bytes are discarded.
- FIFO:
  - Circular buffer with read/write pointers and a count register.
  - A push is accepted iff i_wr_en=1 and count<FIFO_DEPTH, evaluated at that edge. A same-cycle pop does not free a slot for a push when full.
  - A rejected push sets o_overflow=1. o_overflow is cleared only by i_clr_overflow or reset; if both set and clear occur in the same cycle, set wins.
  - Simultaneous accepted push and pop leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - o_full, o_empty and o_count are registered and reflect state after the most recent edge.
- FSM states: IDLE, START, DATA, STOP. o_tx is a registered output.
- IDLE:
  - o_tx=1.
  - If the FIFO is non-empty at an edge: pop the head into the shift register, go to START, drive o_tx=0, zero the baud counter.
  - Net latency: a byte pushed into an empty FIFO while IDLE at edge N gives o_tx=0 from edge N+1.
- START:
  - Hold o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with o_tx = shift[0] and bit index 0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - After bit 7 completes, go to STOP with o_tx=1.
- STOP:
  - Hold o_tx=1 for CLKS_PER_BIT cycles.
  - At completion, if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- o_busy is 1 in START/DATA/STOP, 0 in IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Bit timing is unaffected by FIFO pushes.
- i_wr_data is sampled only on accepted pushes; the line is never altered mid-frame except by reset.

Test Plan:
(Bench parameters: CLK_FREQ=16, UART_BAUD=4 so CLKS_PER_BIT=4; FIFO_DEPTH=4.)
1. Reset: assert i_rst 2 cycles from a random state -> o_tx=1, o_busy=0, o_empty=1, o_count=0, o_overflow=0.
2. Single byte: push 0x55 at edge 0 -> o_tx=0 from edge 1.
   - Bits 1,0,1,0,1,0,1,0 follow, each 4 cycles, then stop bit high 4 cycles.
   - o_busy falls at edge 41; o_count returns to 0 at edge 1.
3. Back-to-back: push 0xA5 then 0x3C on consecutive cycles -> two contiguous frames spanning edges 1..81.
   - Second start bit begins at edge 41 with no idle cycle.
   - Decoded bytes are 0xA5, 0x3C.
4. Overflow: push 0x01..0x06 on six consecutive cycles from idle.
   - 0x01 is popped at edge 1; count reaches 4 (o_full=1) after the fifth push.
   - The 0x06 push is dropped and o_overflow=1.
   - Line carries exactly 0x01..0x05 in order.
   - Pulse i_clr_overflow -> o_overflow=0 next cycle.
5. Reset mid-frame: push 0xFF and 0x00, assert i_rst during the DATA bit 3 of the first frame.
   - o_tx=1, o_empty=1, o_busy=0 the cycle after the reset edge.
   - No further low bits appear on the line.
6. Full with pop: with FIFO full and a frame ending, assert i_wr_en on the STOP completion edge -> push rejected, o_overflow=1, count goes 4->3.
